add_arbiter: RTL and testbench
==============================

# add_arbiter

Round-robin arbiter and sequencer that shares one 6-bit two's-complement adder (`addition`) among `N_REQ` requesters. Each cycle it grants at most one requester, drives that requester's operands into the adder, and captures the sum and overflow flag in a one-entry output register. The result goes out on a single valid/ready response channel tagged with the requester index. A saturating overflow event counter supports status reporting.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters, legal range 2–8.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester tag. Derived; do not override.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  N_REQ: request valid, one bit per requester.
- `req_a`  in  N_REQ×6: packed operand A. Requester i uses bits [6i+5:6i].
- `req_b`  in  N_REQ×6: packed operand B, same packing as `req_a`.
- `req_ready`  out  N_REQ: accept strobe. One-hot or zero.
- `rsp_valid`  out  1: output register holds a result.
- `rsp_ready`  in  1: consumer accepts the result.
- `rsp_z`  out  6: sum.
- `rsp_ovf`  out  1: signed overflow of the sum.
- `rsp_id`  out  ID_W: index of the requester that produced the result.
- `ovf_clr`  in  1: synchronous clear of `ovf_count`.
- `ovf_count`  out  8: saturating count of accepted requests whose sum overflowed.

## Operation
- **Output-register FSM**, two states:
  - EMPTY (`rsp_valid`=0).
  - FULL (`rsp_valid`=1).
- **Transitions:**
  - EMPTY→FULL on accept.
  - FULL→EMPTY on `rsp_ready` with no accept.
  - FULL→FULL on `rsp_ready` with an accept in the same cycle (pass-through, one result per cycle).
  - With `rsp_ready`=0 in FULL: state and all `rsp_*` outputs hold.
- **Grant:** round-robin pointer `ptr` names the highest-priority requester. Priority order is `ptr`, `ptr+1`, … modulo N_REQ. The grant is the first requester in that order with `req_valid` set.
- **Ready:** `req_ready[g] = (state==EMPTY || rsp_ready)` for the granted index g only. All other bits are 0.
- **Accept:** occurs when `req_valid[g] && req_ready[g]`. On accept:
  - Register the adder outputs for `req_a[g]`/`req_b[g]` into `rsp_z`/`rsp_ovf`.
  - Set `rsp_id`=g.
  - Set `ptr` to (g+1) mod N_REQ.
- **Pointer hold:** `ptr` changes only on accept.
- **Arithmetic:** 6-bit two's complement. Sum wraps modulo 64. Overflow = operand sign bits equal and sum sign bit differs. Carry out is discarded.
- **`ovf_count`:**
  - Increments by 1 on each accept whose overflow is 1.
  - Saturates at 255.
  - `ovf_clr` sets it to 0 and takes priority over a same-cycle increment; that increment is lost.
- **Requester stability:** a requester must hold `req_valid` and its operands stable until accepted. The block does not check this.

## Timing
- **Reset values:**
  - `rsp_valid`=0, `rsp_z`=0, `rsp_ovf`=0, `rsp_id`=0, `ovf_count`=0.
  - `ptr`=0 (requester 0 has highest priority).
  - `req_ready` is combinational and therefore 0 while all `req_valid` are 0.
- **Reset mid-operation:** a held, unconsumed result is discarded, with no response.
- **Latency:** accept at edge k ⇒ `rsp_valid`=1 with the result from edge k. Result is visible in cycle k+1.
- **Throughput:** one result per cycle while `rsp_ready`=1.
- **Combinational paths:** `req_ready` depends on `req_valid`, `ptr`, state and `rsp_ready`. No combinational path runs from `req_a`/`req_b` to any output.
- **Adder path:** the adder path is mux → `addition` → register. It must close in one cycle.

## Structure
- **Package `add_arb_pkg`:**
  - `DATA_W`=6.
  - `CNT_W`=8.
  - `CNT_MAX`=8'hFF.
  - `typedef enum logic {EMPTY, FULL} rsp_state_t`.
- **Sub-module:** one instance of the existing `addition` module, fed by the operand mux. Adder logic is not duplicated inside this block.
- **Round-robin grant:** natural as a separate sub-module `rr_grant #(N)`, with inputs req and ptr and a one-hot grant output. It is reusable by other shared ALU units.

## Test plan
- **Single requester:** after reset, req 0 sends a=6'h03, b=6'h04 → `req_ready[0]`=1 the same cycle; next cycle `rsp_valid`=1, `rsp_z`=6'h07, `rsp_ovf`=0, `rsp_id`=0.
- **Overflow cases:**
  - a=6'h14 (20), b=6'h0F (15) → `rsp_z`=6'h23, `rsp_ovf`=1, `ovf_count`=1.
  - a=6'h20, b=6'h3F → `rsp_z`=6'h1F, `rsp_ovf`=1, `ovf_count`=2.
- **Fairness:** both requesters hold valid for 4 cycles with `rsp_ready`=1 → `rsp_id` sequence 0,1,0,1, one result per cycle.
- **Backpressure:** `rsp_ready`=0 while FULL → all `req_ready`=0, and `rsp_z`/`rsp_id` hold for 5 cycles. Raising `rsp_ready` pops the held result and accepts the next request in the same cycle.
- **Counter limits:** 256 overflowing requests → `ovf_count` saturates at 255. Then assert `ovf_clr` and an overflowing accept in the same cycle → `ovf_count`=0.
- **Reset mid-operation:** assert `rst_n`=0 while FULL with `rsp_ready`=0 → `rsp_valid`=0 asynchronously. After release, req 1 alone is granted, and then req 0 has priority again (ptr=0 after reset).

Source files
------------

// File: rtl/add_arbiter_pkg.sv
// Shared constants and types for the shared-adder arbiter.
package add_arb_pkg;

    localparam int DATA_W = 6;
    localparam int CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

    typedef enum logic {EMPTY, FULL} rsp_state_t;

endpackage

// File: rtl/add_arbiter_if.sv
// Request/response bus between requesters (master) and the arbiter (slave).
interface add_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
);
    import add_arb_pkg::*;

    // A transfer happens on a rising edge where valid && ready are both 1;
    // the sender holds valid and payload stable until that edge.
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_W-1:0]       rsp_z;
    logic                    rsp_ovf;
    logic [ID_W-1:0]         rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_z, rsp_ovf, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_z, rsp_ovf, rsp_id
    );

endinterface

// File: rtl/add_arbiter_rr_grant.sv
// Round-robin grant: first set request at or after ptr (mod N), one-hot out.
module rr_grant #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) idx = idx - N;
            // Constant-index compare keeps the select free of wide dynamic indexing.
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (i == idx)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/addition.sv
// 6-bit two's-complement adder with signed-overflow flag; carry out is dropped.
module addition
    import add_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] z,
    output logic              ovf
);

    assign z   = a + b;
    assign ovf = (a[DATA_W-1] == b[DATA_W-1]) && (z[DATA_W-1] != a[DATA_W-1]);

endmodule

// File: rtl/add_arbiter.sv
// Shares one adder among N_REQ requesters; one-entry result register with
// valid/ready output and a saturating overflow counter.
module add_arbiter
    import add_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    add_arbiter_if.slave     bus,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] ovf_count,
    output rsp_state_t       dbg_state
);

    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   g_idx;
    logic [DATA_W-1:0] a_sel, b_sel, sum;
    logic              sum_ovf, can_load, accept;

    rsp_state_t        state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0] z_q, z_d;
    logic              ovf_q, ovf_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    rr_grant #(.N(N_REQ), .PW(ID_W)) u_grant (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        g_idx = '0;
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                g_idx = ID_W'(i);
                a_sel = bus.req_a[i*DATA_W +: DATA_W];
                b_sel = bus.req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    addition u_add (
        .a   (a_sel),
        .b   (b_sel),
        .z   (sum),
        .ovf (sum_ovf)
    );

    // The register can take a new result when empty or when it is being drained.
    assign can_load      = (state_q == EMPTY) || bus.rsp_ready;
    assign accept        = can_load && (|grant);
    assign bus.req_ready = can_load ? grant : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        z_d     = z_q;
        ovf_d   = ovf_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = FULL;
            z_d     = sum;
            ovf_d   = sum_ovf;
            id_d    = g_idx;
            ptr_d   = (g_idx == ID_W'(N_REQ - 1)) ? '0 : g_idx + ID_W'(1);
        end else if ((state_q == FULL) && bus.rsp_ready) begin
            state_d = EMPTY;
        end
        if (ovf_clr) begin
            cnt_d = '0;
        end else if (accept && sum_ovf && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            z_q     <= '0;
            ovf_q   <= 1'b0;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            z_q     <= z_d;
            ovf_q   <= ovf_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_z     = z_q;
    assign bus.rsp_ovf   = ovf_q;
    assign bus.rsp_id    = id_q;
    assign ovf_count     = cnt_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: handshake, arithmetic, fairness,
// backpressure, counter saturation/clear and asynchronous reset.
module tb_add_arbiter;
    import add_arb_pkg::*;

    localparam int N_REQ = 2;

    logic       clk;
    logic       rst_n;
    logic       ovf_clr;
    logic [7:0] ovf_count;
    rsp_state_t dbg_state;

    int checks   = 0;
    int failures = 0;

    add_arbiter_if #(.N_REQ(N_REQ)) bus ();

    add_arbiter #(.N_REQ(N_REQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ovf_clr   (ovf_clr),
        .ovf_count (ovf_count),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [5:0] a, input logic [5:0] b);
        bus.req_a[i*6 +: 6] = a;
        bus.req_b[i*6 +: 6] = b;
    endtask

    task automatic chk_rsp(input string tag, input logic [5:0] z, input logic ovf, input logic id);
        chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_z"},     32'(bus.rsp_z),     32'(z));
        chk({tag, "_ovf"},   32'(bus.rsp_ovf),   32'(ovf));
        chk({tag, "_id"},    32'(bus.rsp_id),    32'(id));
    endtask

    initial begin
        rst_n         = 1'b0;
        ovf_clr       = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_z",     32'(bus.rsp_z),     32'd0);
        chk("rst_ovf",   32'(bus.rsp_ovf),   32'd0);
        chk("rst_id",    32'(bus.rsp_id),    32'd0);
        chk("rst_cnt",   32'(ovf_count),     32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_state", 32'(dbg_state),     32'(EMPTY));
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Single requester: 3 + 4 = 7
        bus.req_valid = 2'b01;
        set_req(0, 6'h03, 6'h04);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("single_ready", 32'(bus.req_ready), 32'h1);
        cyc();
        bus.req_valid = 2'b00;
        chk_rsp("single", 6'h07, 1'b0, 1'b0);
        chk("single_state", 32'(dbg_state), 32'(FULL));
        cyc();
        chk("drain_valid", 32'(bus.rsp_valid), 32'd0);

        // Overflow: 20 + 15 = 35 -> 0x23, then 0x20 + 0x3F -> 0x1F (pass-through)
        bus.req_valid = 2'b01;
        set_req(0, 6'h14, 6'h0F);
        cyc();
        chk_rsp("ovf1", 6'h23, 1'b1, 1'b0);
        chk("ovf1_cnt", 32'(ovf_count), 32'd1);
        set_req(0, 6'h20, 6'h3F);
        cyc();
        chk_rsp("ovf2", 6'h1F, 1'b1, 1'b0);
        chk("ovf2_cnt", 32'(ovf_count), 32'd2);
        bus.req_valid = 2'b00;
        cyc();

        // Requester 1 alone: 5 + (-2) = 3; pointer then wraps to 0
        bus.req_valid = 2'b10;
        set_req(1, 6'h05, 6'h3E);
        @(negedge clk);
        chk("r1_ready", 32'(bus.req_ready), 32'h2);
        cyc();
        chk_rsp("r1", 6'h03, 1'b0, 1'b1);
        bus.req_valid = 2'b00;
        cyc();

        // Fairness: both valid, rsp_ready=1 -> ids 0,1,0,1 back to back
        bus.req_valid = 2'b11;
        set_req(0, 6'h01, 6'h01);
        set_req(1, 6'h02, 6'h02);
        @(negedge clk);
        chk("fair0_ready", 32'(bus.req_ready), 32'h1);
        cyc();
        chk_rsp("fair0", 6'h02, 1'b0, 1'b0);
        @(negedge clk);
        chk("fair1_ready", 32'(bus.req_ready), 32'h2);
        cyc();
        chk_rsp("fair1", 6'h04, 1'b0, 1'b1);
        cyc();
        chk_rsp("fair2", 6'h02, 1'b0, 1'b0);
        cyc();
        chk_rsp("fair3", 6'h04, 1'b0, 1'b1);

        // Backpressure: held result id 1, z 4
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_ready", 32'(bus.req_ready), 32'h0);
            cyc();
            chk_rsp("bp_hold", 6'h04, 1'b0, 1'b1);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(bus.req_ready), 32'h1);
        cyc();
        chk_rsp("bp_next", 6'h02, 1'b0, 1'b0);
        bus.req_valid = 2'b00;
        cyc();
        chk("bp_cnt", 32'(ovf_count), 32'd2);

        // Counter saturation: 31 + 1 overflows every accept
        bus.req_valid = 2'b01;
        set_req(0, 6'h1F, 6'h01);
        repeat (252) cyc();
        chk("sat_254", 32'(ovf_count), 32'd254);
        cyc();
        chk("sat_255", 32'(ovf_count), 32'd255);
        repeat (3) cyc();
        chk("sat_hold", 32'(ovf_count), 32'd255);
        chk_rsp("sat_rsp", 6'h20, 1'b1, 1'b0);
        ovf_clr = 1'b1;
        cyc();
        chk("clr_wins", 32'(ovf_count), 32'd0);
        ovf_clr = 1'b0;
        cyc();
        chk("clr_then_inc", 32'(ovf_count), 32'd1);
        bus.req_valid = 2'b00;
        cyc();

        // Reset while FULL and stalled; ptr is 1 here
        bus.req_valid = 2'b01;
        set_req(0, 6'h03, 6'h04);
        bus.rsp_ready = 1'b0;
        cyc();
        bus.req_valid = 2'b00;
        chk("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("async_rst_cnt",   32'(ovf_count),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        chk("post_rst_prio", 32'(bus.req_ready), 32'h1);
        bus.req_valid = 2'b10;
        set_req(1, 6'h0A, 6'h01);
        cyc();
        chk_rsp("post_rst_r1", 6'h0B, 1'b0, 1'b1);
        bus.req_valid = 2'b11;
        @(negedge clk);
        chk("post_rst_r0_prio", 32'(bus.req_ready), 32'h1);
        cyc();
        chk_rsp("post_rst_r0", 6'h07, 1'b0, 1'b0);
        bus.req_valid = 2'b00;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
